// File: rtl/multiport_mem_ctrl.sv
// multiport_mem_ctrl: arbitrates NUM_PORTS line requesters onto one single-ported RAM
// with fixed access/response latency. Define MULTIPORT_MEM_CTRL_RR_EN for round-robin grants.
//
// state  | meaning
// S_IDLE | waiting for an eligible request; grant latched on the edge that leaves
// S_ACC  | counting ACC_LAT edges towards the RAM access strobe
// S_RSP  | read issued, counting RSP_LAT edges towards the response sample
// S_WACK | write strobe and wr_ack cycle
// S_RACK | rsp_valid cycle
module multiport_mem_ctrl #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 26,
  parameter int LINE_W    = 128,
  parameter int ACC_LAT   = 5,
  parameter int RSP_LAT   = 5
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [NUM_PORTS-1:0]        i_req,
  input  logic [NUM_PORTS-1:0]        i_req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_PORTS*LINE_W-1:0] i_req_wdata,
  output logic [NUM_PORTS-1:0]        o_rsp_valid,
  output logic [LINE_W-1:0]           o_rsp_rdata,
  output logic [NUM_PORTS-1:0]        o_wr_ack,
  output logic                        o_busy,
  output logic                        o_mem_en,
  output logic                        o_mem_we,
  output logic [ADDR_W-1:0]           o_mem_addr,
  output logic [LINE_W-1:0]           o_mem_wdata,
  input  logic [LINE_W-1:0]           i_mem_rdata
);

  localparam int GW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int MAXL = (ACC_LAT > RSP_LAT) ? ACC_LAT : RSP_LAT;
  localparam int CW   = $clog2(MAXL + 1);
  localparam logic [CW-1:0] ACC_LD = CW'(ACC_LAT - 1);
  localparam logic [CW-1:0] RSP_LD = CW'(RSP_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_RSP,
    S_WACK,
    S_RACK
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [GW-1:0]         r_gnt;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [LINE_W-1:0]     r_wdata;
  logic [NUM_PORTS-1:0]  r_served;
  logic [NUM_PORTS-1:0]  r_rsp_valid;
  logic [LINE_W-1:0]     r_rsp_rdata;
  logic [NUM_PORTS-1:0]  r_wr_ack;
  logic                  r_busy;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [LINE_W-1:0]     r_mem_wdata;

  logic [NUM_PORTS-1:0]  w_elig;
  logic                  w_any;
  logic [GW-1:0]         w_gnt;
  logic                  w_sel_we;
  logic [ADDR_W-1:0]     w_sel_addr;
  logic [LINE_W-1:0]     w_sel_wdata;
  logic [NUM_PORTS-1:0]  w_gnt_oh;

  // The port just served is masked for one IDLE cycle so a late-dropped req is not regranted.
  assign w_elig   = i_req & ~r_served;
  assign w_gnt_oh = NUM_PORTS'(1) << r_gnt;

`ifdef MULTIPORT_MEM_CTRL_RR_EN
  logic [GW-1:0]        r_rr_ptr;
  logic [NUM_PORTS-1:0] w_rot;
  logic [GW-1:0]        w_next_ptr;

  always_comb begin
    w_rot = NUM_PORTS'({w_elig, w_elig} >> r_rr_ptr);
    w_any = 1'b0;
    w_gnt = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_any && w_rot[i]) begin
        w_any = 1'b1;
        w_gnt = GW'((int'(r_rr_ptr) + i) % NUM_PORTS);
      end
    end
  end

  assign w_next_ptr = (w_gnt == GW'(NUM_PORTS - 1)) ? '0 : w_gnt + 1'b1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rr_ptr <= '0;
    end else if (r_state == S_IDLE && w_any) begin
      r_rr_ptr <= w_next_ptr;
    end
  end
`else
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_any && w_elig[i]) begin
        w_any = 1'b1;
        w_gnt = GW'(i);
      end
    end
  end
`endif

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_gnt == GW'(i)) begin
        w_sel_we    = i_req_we[i];
        w_sel_addr  = i_req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = i_req_wdata[i*LINE_W +: LINE_W];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_served    <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_wr_ack    <= '0;
      r_busy      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_wr_ack    <= '0;
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          r_served <= '0;
          if (w_any) begin
            r_gnt   <= w_gnt;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_cnt   <= ACC_LD;
            r_busy  <= 1'b1;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          if (r_cnt == '0) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= r_we;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= r_wdata;
            if (r_we) begin
              r_wr_ack <= w_gnt_oh;
              r_state  <= S_WACK;
            end else begin
              r_cnt   <= RSP_LD;
              r_state <= S_RSP;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RSP: begin
          if (r_cnt == '0) begin
            r_rsp_rdata <= i_mem_rdata;
            r_rsp_valid <= w_gnt_oh;
            r_state     <= S_RACK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WACK, S_RACK: begin
          r_served <= w_gnt_oh;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_wr_ack    = r_wr_ack;
  assign o_busy      = r_busy;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_multiport_mem_ctrl.sv
// tb_multiport_mem_ctrl: randomized and directed requests against a transaction-level
// model of the controller (grant rule, fixed latencies, RAM contents).
module tb_multiport_mem_ctrl;

  localparam int NP = 2;
  localparam int AW = 26;
  localparam int LW = 128;
  localparam int AL = 5;
  localparam int RL = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   req, req_we;
  logic [NP*AW-1:0] req_addr;
  logic [NP*LW-1:0] req_wdata;
  logic [NP-1:0]   rsp_valid, wr_ack;
  logic [LW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
  logic            busy, mem_en, mem_we;
  logic [AW-1:0]   mem_addr;

  int total = 0;
  int bad   = 0;

  logic [NP-1:0] pend;
  bit            p_we    [NP];
  logic [AW-1:0] p_addr  [NP];
  logic [LW-1:0] p_wdata [NP];
  int            rr_ptr = 0;
  bit            late_hold = 0;
  bit            force_reissue = 0;
  logic [LW-1:0] ram [logic [AW-1:0]];

  multiport_mem_ctrl #(
    .NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW), .ACC_LAT(AL), .RSP_LAT(RL)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_wr_ack(wr_ack),
    .o_busy(busy), .o_mem_en(mem_en), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] ram_rd(input logic [AW-1:0] a);
    if (ram.exists(a)) return ram[a];
    return {4{6'b0, a}};
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [NP-1:0] oh(input int p);
    logic [NP-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Grant rule: round-robin from the pointer, or lowest index first.
  function automatic int pick(input logic [NP-1:0] elig);
`ifdef MULTIPORT_MEM_CTRL_RR_EN
    for (int i = 0; i < NP; i++) begin
      int p;
      p = (rr_ptr + i) % NP;
      if (elig[p]) return p;
    end
`else
    for (int i = 0; i < NP; i++) if (elig[i]) return i;
`endif
    return -1;
  endfunction

  task automatic set_port(input int p, input bit we, input logic [AW-1:0] a, input logic [LW-1:0] d);
    p_we[p] = we; p_addr[p] = a; p_wdata[p] = d; pend[p] = 1'b1;
    req[p] = 1'b1; req_we[p] = we;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*LW +: LW] = d;
  endtask

  task automatic rand_port(input int p);
    set_port(p, bit'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), rnd_line());
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, ".busy"}, busy, 0);
    check_val({tag, ".mem_en"}, mem_en, 0);
    check_val({tag, ".wr_ack"}, wr_ack, 0);
    check_val({tag, ".rsp_valid"}, rsp_valid, 0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      check_quiet("idle");
    end
  endtask

  // Serves every pending request; expected timing is counted from the grant edge E0.
  task automatic serve_all(input int budget);
    logic [NP-1:0] blocked, elig;
    int g, drop_p;
    bit we, late;
    logic [AW-1:0] a;
    logic [LW-1:0] d, exp_rd;
    blocked = '0;
    drop_p = -1;
    exp_rd = '0;
    while (pend != '0) begin
      elig = pend & ~blocked;
      @(posedge clk);
      blocked = '0;
      if (elig == '0) begin
        @(negedge clk);
        if (drop_p >= 0) begin req[drop_p] = 1'b0; drop_p = -1; end
        check_quiet("masked_idle");
        continue;
      end
      g = pick(elig);
`ifdef MULTIPORT_MEM_CTRL_RR_EN
      rr_ptr = (g + 1) % NP;
`endif
      we = p_we[g]; a = p_addr[g]; d = p_wdata[g];
      pend[g] = 1'b0;
      @(negedge clk);
      if (drop_p >= 0) begin req[drop_p] = 1'b0; drop_p = -1; end
      check_val("acc.busy", busy, 1);
      check_val("acc.mem_en", mem_en, 0);
      req_we[g] = ~req_we[g];
      req_addr[g*AW +: AW] = AW'($urandom());
      req_wdata[g*LW +: LW] = rnd_line();
      for (int k = 1; k < AL; k++) begin
        @(negedge clk);
        check_val("acc.mem_en", mem_en, 0);
        check_val("acc.wr_ack", wr_ack, 0);
        check_val("acc.rsp_valid", rsp_valid, 0);
        check_val("acc.busy", busy, 1);
      end
      @(negedge clk);
      check_val("mem.en", mem_en, 1);
      check_val("mem.we", mem_we, we);
      check_val("mem.addr", mem_addr, a);
      check_val("mem.wr_ack", wr_ack, we ? oh(g) : '0);
      check_val("mem.rsp_valid", rsp_valid, 0);
      if (we) begin
        check_val("mem.wdata", mem_wdata, d);
        ram[a] = d;
      end else begin
        exp_rd = ram_rd(a);
        mem_rdata = (RL == 1) ? ram_rd(mem_addr) : rnd_line();
        for (int k = 1; k < RL; k++) begin
          @(negedge clk);
          check_val("rsp.rsp_valid", rsp_valid, 0);
          check_val("rsp.mem_en", mem_en, 0);
          check_val("rsp.busy", busy, 1);
          if (k == RL - 1) mem_rdata = ram_rd(mem_addr);
        end
        @(negedge clk);
        check_val("rack.rsp_valid", rsp_valid, oh(g));
        check_val("rack.rsp_rdata", rsp_rdata, exp_rd);
        check_val("rack.wr_ack", wr_ack, 0);
        mem_rdata = rnd_line();
      end
      late = late_hold || ($urandom_range(0, 3) == 0);
      if (!late) req[g] = 1'b0;
      @(negedge clk);
      check_quiet("post_ack");
      if (!we) check_val("hold.rsp_rdata", rsp_rdata, exp_rd);
      if (budget > 0 && (force_reissue || $urandom_range(0, 1) == 1)) begin
        rand_port(g);
        budget--;
      end else if (late) begin
        drop_p = g;
      end
      blocked = oh(g);
    end
    if (drop_p >= 0) begin
      @(posedge clk);
      @(negedge clk);
      req[drop_p] = 1'b0;
      check_quiet("late_drop");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_rdata = '0; pend = '0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check_val("reset.mem_we", mem_we, 0);
    check_val("reset.mem_addr", mem_addr, 0);
    check_val("reset.mem_wdata", mem_wdata, 0);
    check_val("reset.rsp_rdata", rsp_rdata, 0);
    rst = 1'b0;
    idle_cycles(3);

    ram[26'h0000ABC] = {4{32'hDEAD_BEEF}};
    set_port(1, 1'b0, 26'h0000ABC, rnd_line());
    serve_all(0);
    check_val("t1.rdata", rsp_rdata, {4{32'hDEAD_BEEF}});
    idle_cycles(2);

    set_port(0, 1'b1, 26'h0001234, {16{8'h55}});
    serve_all(0);
    idle_cycles(2);

    set_port(0, 1'b0, 26'h0000ABC, rnd_line());
    set_port(1, 1'b0, 26'h0000777, rnd_line());
    serve_all(0);
    idle_cycles(2);

    force_reissue = 1'b1;
    set_port(0, 1'b0, 26'h0001234, rnd_line());
    set_port(1, 1'b0, 26'h0000ABC, rnd_line());
    serve_all(2);
    force_reissue = 1'b0;
    idle_cycles(2);

    set_port(1, 1'b0, 26'h0000ABC, rnd_line());
    @(posedge clk);
    repeat (AL + 3) @(negedge clk);
    check_val("t5.pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_val("t5.busy", busy, 0);
    check_val("t5.mem_en", mem_en, 0);
    check_val("t5.mem_we", mem_we, 0);
    check_val("t5.mem_addr", mem_addr, 0);
    check_val("t5.mem_wdata", mem_wdata, 0);
    check_val("t5.rsp_valid", rsp_valid, 0);
    check_val("t5.rsp_rdata", rsp_rdata, 0);
    check_val("t5.wr_ack", wr_ack, 0);
    req = '0; pend = '0; rr_ptr = 0;
    repeat (3) begin
      @(negedge clk);
      check_val("t5.rst_rsp_valid", rsp_valid, 0);
      check_val("t5.rst_busy", busy, 0);
    end
    rst = 1'b0;
    idle_cycles(1);
    set_port(1, 1'b0, 26'h0000ABC, rnd_line());
    serve_all(0);
    check_val("t5.rdata", rsp_rdata, {4{32'hDEAD_BEEF}});
    idle_cycles(2);

    late_hold = 1'b1;
    set_port(0, 1'b1, 26'h0000042, rnd_line());
    set_port(1, 1'b0, 26'h0000042, rnd_line());
    serve_all(0);
    late_hold = 1'b0;
    idle_cycles(2);

    for (int ep = 0; ep < 40; ep++) begin
      logic [NP-1:0] mask;
      mask = NP'($urandom_range(1, (1 << NP) - 1));
      for (int p = 0; p < NP; p++) if (mask[p]) rand_port(p);
      serve_all($urandom_range(0, 3));
      idle_cycles($urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
